data_memory_banked: RTL and testbench

Parametrised successor to the processor's data memory: a synchronous word-addressed RAM with configurable width and depth, per-byte write enables, address checking and a post-reset clear sweep. It sits on the load/store path of the datapath. Read data is qualified by a valid strobe, so the pipeline never consumes stale `d_out`.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 50 +++++
 rtl/data_memory_banked.sv | 119 +++++++++++
 tb/tb_data_memory_banked.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the banked data memory: FSM state encoding,
// default geometry and the byte-offset helper.
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4096;
    localparam int DEF_ADDR_W = 32;

    // Number of low byte-address bits that select a byte within a word.
    function automatic int calc_off(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: single-port, byte-enabled, read-before-write, registered output.
// 1-cycle read latency; no backpressure, one access per cycle.
import dmem_pkg::*;

module dmem_array #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                re,
    input  logic [DATA_W/8-1:0] we,
    input  logic [IDX_W-1:0]    addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // Storage has no reset so it maps onto RAM macros; the sweep clears it.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_banked.sv
// Word-addressed data RAM with byte enables, address checking and a post-reset clear sweep.
// Read/err latency 1 cycle; requests ignored (busy=1) for DEPTH cycles after reset, never stalls after.
import dmem_pkg::*;

module data_memory_banked #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                rd,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   add_lines,
    input  logic [DATA_W-1:0]   d_in,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   d_out,
    output logic                rd_valid,
    output logic                busy,
    output logic                err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = calc_off(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);

    state_e           state_d, state_q;
    logic [IDX_W-1:0] ptr_d, ptr_q;
    logic             busy_d, busy_q;
    logic             rd_valid_d, rd_valid_q;
    logic             err_d, err_q;

    logic [ADDR_W-1:0]   word_idx;
    logic                misaligned, out_of_range, addr_ok, is_ready;
    logic                arr_re;
    logic [BYTES-1:0]    arr_we;
    logic [IDX_W-1:0]    arr_addr;
    logic [DATA_W-1:0]   arr_wdata;

    // Range check is done at full address width so no upper bits are silently dropped.
    always_comb begin
        word_idx     = add_lines >> OFF;
        misaligned   = (add_lines & ADDR_W'(BYTES - 1)) != '0;
        out_of_range = {32'd0, word_idx} >= (ADDR_W + 32)'(DEPTH);
        addr_ok      = !misaligned && !out_of_range;
        is_ready     = (state_q == READY);
    end

    always_comb begin
        arr_re    = is_ready && rd && addr_ok;
        arr_we    = '0;
        arr_addr  = word_idx[IDX_W-1:0];
        arr_wdata = d_in;
        if (!is_ready) begin
            arr_we    = '1;
            arr_addr  = ptr_q;
            arr_wdata = '0;
        end else if (wr && addr_ok) begin
            arr_we = byte_en;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                rd_valid_d = rd && addr_ok;
                err_d      = (rd || wr) && !addr_ok;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .CLK   (CLK),
        .RST   (RST),
        .re    (arr_re),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (d_out)
    );

    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench for data_memory_banked (DATA_W=32, DEPTH=16) with an expectation queue.
module tb_data_memory_banked;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rd = 1'b0, wr = 1'b0;
    logic [AW-1:0] add_lines = '0;
    logic [DW-1:0] d_in = '0;
    logic [3:0]    byte_en = '0;
    logic [DW-1:0] d_out;
    logic          rd_valid, busy, err;

    typedef struct {
        string       tag;
        logic        vld;
        logic        er;
        logic [31:0] dout;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_dout = '0;

    data_memory_banked #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .rd(rd), .wr(wr), .add_lines(add_lines),
        .d_in(d_in), .byte_en(byte_en), .d_out(d_out), .rd_valid(rd_valid),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request, queue its expected outcome, compare #1 after the sampling edge.
    task automatic issue(input string tag, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] din, input logic [3:0] be,
                         input logic exp_vld, input logic exp_err, input logic [31:0] rdat);
        exp_t e;
        @(negedge CLK);
        rd = r; wr = w; add_lines = a; d_in = din; byte_en = be;
        if (exp_vld) cur_dout = rdat;
        sb.push_back('{tag, exp_vld, exp_err, cur_dout});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, e.vld});
        chk({e.tag, ".err"}, {31'd0, err}, {31'd0, e.er});
        chk({e.tag, ".d_out"}, d_out, e.dout);
        rd = 1'b0; wr = 1'b0;
    endtask

    // Counts edges with busy high after release; requests held asserted must stay ignored.
    task automatic sweep(input string tag, input int stop_after);
        int n = 0;
        @(negedge CLK);
        RST = 1'b0;
        rd = 1'b1; wr = 1'b1; add_lines = '0; d_in = '1; byte_en = '1;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            n++;
            chk({tag, ".sweep_rd_valid"}, {31'd0, rd_valid}, 32'd0);
            chk({tag, ".sweep_err"}, {31'd0, err}, 32'd0);
            if (!busy || n == stop_after) break;
        end
        rd = 1'b0; wr = 1'b0;
        chk({tag, ".busy_edges"}, n, (stop_after > 0) ? stop_after : DP);
        if (stop_after > 0) chk({tag, ".busy_still"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".d_out"}, d_out, 32'd0);
        chk({tag, ".rd_valid"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, ".err"}, {31'd0, err}, 32'd0);
        cur_dout = '0;
    endtask

    initial begin
        #12;
        check_reset_outputs("por");
        sweep("sweep1", 0);

        issue("rd_w5", 1, 0, 32'h14, 0, 0, 1, 0, 32'h0);
        issue("rd_w0_after_busy_wr", 1, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        issue("wr_be0101", 0, 1, 32'h8, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        issue("rd_be0101", 1, 0, 32'h8, 0, 0, 1, 0, 32'h00BB00DD);
        issue("wr_be0000", 0, 1, 32'h8, 32'h12345678, 4'b0000, 0, 0, 0);
        issue("rd_be0000", 1, 0, 32'h8, 0, 0, 1, 0, 32'h00BB00DD);

        issue("wr_11", 0, 1, 32'h4, 32'h11, 4'hF, 0, 0, 0);
        issue("rbw", 1, 1, 32'h4, 32'h22, 4'hF, 1, 0, 32'h11);
        issue("rd_after_rbw", 1, 0, 32'h4, 0, 0, 1, 0, 32'h22);

        issue("rd_misaligned", 1, 0, 32'h6, 0, 0, 0, 1, 0);
        issue("wr_misaligned", 0, 1, 32'h5, 32'hDEAD, 4'hF, 0, 1, 0);
        issue("rd_w5_again", 1, 0, 32'h14, 0, 0, 1, 0, 32'h0);

        issue("wr_last", 0, 1, 32'h3C, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        issue("wr_oor", 0, 1, DP * 4, 32'h0BADBEEF, 4'hF, 0, 1, 0);
        issue("wr_oor_high", 0, 1, 32'h8000_003C, 32'h0BADBEEF, 4'hF, 0, 1, 0);
        issue("rd_last", 1, 0, 32'h3C, 0, 0, 1, 0, 32'hCAFEF00D);
        issue("rd_w0_wrap", 1, 0, 32'h0, 0, 0, 1, 0, 32'h0);

        issue("wr_w0", 0, 1, 32'h0, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
        issue("rd_w0", 1, 0, 32'h0, 0, 0, 1, 0, 32'h5A5A5A5A);

        // Reset lands mid-cycle while a read is being presented.
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("rst_mid_access");

        sweep("partial", 7);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("rst_mid_sweep");
        sweep("sweep2", 0);

        issue("rd_w0_cleared", 1, 0, 32'h0, 0, 0, 1, 0, 32'h0);
        issue("rd_w2_cleared", 1, 0, 32'h8, 0, 0, 1, 0, 32'h0);
        issue("rd_last_cleared", 1, 0, 32'h3C, 0, 0, 1, 0, 32'h0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
